hazard_ctrl_unit: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage core.
- Combines EX-operand forwarding, store-data forwarding, multi-cycle load-use stalls, multi/div busy stalls, branch flushes and a stall-cycle performance counter.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold, bubble and flush controls.

---
 rtl/hazard_ctrl_unit.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard controller for the 5-stage core. It resolves EX operand and
// store-data forwarding, inserts load-use and mul/div stalls, flushes on taken
// branches and counts stalled cycles.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   id_rs1/id_rs2                  ID-stage source registers
//   ex_rs1/ex_rs2/ex_rd            EX-stage sources and destination
//   mem_rs2/mem_rd                 MEM-stage store source and destination
//   wb_rd                          WB-stage destination
//   ex_reg_write/ex_mem_read       EX writes a register / is a load
//   ex_md_start                    EX holds a mul/div operation
//   ex_branch_taken                EX resolved a taken branch/jump
//   mem_reg_write/mem_mem_write    MEM writes a register / is a store
//   wb_reg_write                   WB writes a register
//   md_done                        mul/div result valid this cycle
//   stall_pc/stall_ifid/stall_idex hold PC, IF/ID, ID/EX
//   bubble_idex/bubble_exmem       load NOP into ID/EX, EX/MEM
//   flush_ifid/flush_idex          squash IF/ID, ID/EX
//   bus_a_fw/bus_b_fw              EX operand select: 00 regfile, 10 MEM, 01 WB
//   di_src                         store data taken from the WB result
//   stall_cnt                      saturating count of cycles with stall_pc
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int REG_AW       = 5,
    parameter int LD_STALL_CYC = 1,
    parameter int FWD_EN       = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_md_start,
    input  logic              ex_branch_taken,
    input  logic              mem_reg_write,
    input  logic              mem_mem_write,
    input  logic              wb_reg_write,
    input  logic              md_done,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              stall_idex,
    output logic              bubble_idex,
    output logic              bubble_exmem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [1:0]        bus_a_fw,
    output logic [1:0]        bus_b_fw,
    output logic              di_src,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, LD_STALL, MD_WAIT} state_t;

    localparam bit       NO_FWD    = (FWD_EN == 0);
    localparam logic [3:0] LD_RELOAD = 4'(LD_STALL_CYC - 1);

    state_t            r_state;
    logic [3:0]        r_ldCnt;
    logic              r_rstDly;
    logic [PERF_W-1:0] r_stallCnt;

    state_t     w_nextState;
    logic [3:0] w_nextCnt;
    logic       w_quiet;
    logic       w_loadUse;
    logic       w_raw;

    // True when a nonzero ID source is about to be written by any later stage.
    function automatic logic srcPending(input logic [REG_AW-1:0] src);
        return (src != '0) &&
               ((ex_reg_write  && (ex_rd  == src)) ||
                (mem_reg_write && (mem_rd == src)) ||
                (wb_reg_write  && (wb_rd  == src)));
    endfunction

    // Operand select for one EX source; the younger MEM result wins over WB.
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src))
            return 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Every output is held low during reset and for one cycle afterwards so the
    // pipeline registers can settle before hazard control resumes.
    assign w_quiet   = rst | r_rstDly;
    assign w_loadUse = ex_mem_read && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign w_raw     = NO_FWD && (srcPending(id_rs1) || srcPending(id_rs2));

    // Forwarding is purely combinational and is independent of the FSM state.
    always_comb begin
        bus_a_fw = 2'b00;
        bus_b_fw = 2'b00;
        di_src   = 1'b0;
        if (!NO_FWD && !w_quiet) begin
            bus_a_fw = fwdSel(ex_rs1);
            bus_b_fw = fwdSel(ex_rs2);
            di_src   = wb_reg_write && mem_mem_write &&
                       (wb_rd != '0) && (wb_rd == mem_rs2);
        end
    end

    // Stall/flush decode and next-state logic. In RUN only the highest-priority
    // event acts: branch, then mul/div, then load-use, then plain RAW.
    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        w_nextState  = r_state;
        w_nextCnt    = r_ldCnt;
        case (r_state)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (ex_md_start && !md_done) begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    stall_idex   = 1'b1;
                    bubble_exmem = 1'b1;
                    w_nextState  = MD_WAIT;
                end else if (w_loadUse) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (LD_STALL_CYC > 1) begin
                        w_nextState = LD_STALL;
                        w_nextCnt   = LD_RELOAD;
                    end
                end else if (w_raw) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            LD_STALL: begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                bubble_idex = 1'b1;
                w_nextCnt   = r_ldCnt - 4'd1;
                if (r_ldCnt <= 4'd1)
                    w_nextState = RUN;
            end
            MD_WAIT: begin
                if (md_done) begin
                    w_nextState = RUN;
                end else begin
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    stall_idex   = 1'b1;
                    bubble_exmem = 1'b1;
                end
            end
            default: w_nextState = RUN;
        endcase
        if (w_quiet) begin
            stall_pc     = 1'b0;
            stall_ifid   = 1'b0;
            stall_idex   = 1'b0;
            bubble_idex  = 1'b0;
            bubble_exmem = 1'b0;
            flush_ifid   = 1'b0;
            flush_idex   = 1'b0;
            w_nextState  = RUN;
            w_nextCnt    = 4'd0;
        end
    end

    // State, load counter, reset-delay flag and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_ldCnt    <= 4'd0;
            r_rstDly   <= 1'b1;
            r_stallCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_ldCnt  <= w_nextCnt;
            r_rstDly <= 1'b0;
            if (stall_pc && !(&r_stallCnt))
                r_stallCnt <= r_stallCnt + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = w_quiet ? '0 : r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Directed bench for hazard_ctrl_unit. dutA runs with forwarding and a 3-cycle
// load-use stall; dutB runs without forwarding and with a 3-bit stall counter
// so saturation is reachable. Both see the same stimulus.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rs2, mem_rd, wb_rd;
    logic       ex_reg_write, ex_mem_read, ex_md_start, ex_branch_taken;
    logic       mem_reg_write, mem_mem_write, wb_reg_write, md_done;

    logic        aStallPc, aStallIfid, aStallIdex, aBubIdex, aBubExmem;
    logic        aFlushIfid, aFlushIdex, aDiSrc;
    logic [1:0]  aBusA, aBusB;
    logic [31:0] aCnt;

    logic        bStallPc, bStallIfid, bStallIdex, bBubIdex, bBubExmem;
    logic        bFlushIfid, bFlushIdex, bDiSrc;
    logic [1:0]  bBusA, bBusB;
    logic [2:0]  bCnt;

    int testCount = 0;
    int errCount  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .LD_STALL_CYC(3), .FWD_EN(1), .PERF_W(32)) dutA (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .mem_rs2(mem_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .md_done(md_done),
        .stall_pc(aStallPc), .stall_ifid(aStallIfid), .stall_idex(aStallIdex),
        .bubble_idex(aBubIdex), .bubble_exmem(aBubExmem),
        .flush_ifid(aFlushIfid), .flush_idex(aFlushIdex),
        .bus_a_fw(aBusA), .bus_b_fw(aBusB), .di_src(aDiSrc), .stall_cnt(aCnt)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LD_STALL_CYC(1), .FWD_EN(0), .PERF_W(3)) dutB (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .mem_rs2(mem_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .md_done(md_done),
        .stall_pc(bStallPc), .stall_ifid(bStallIfid), .stall_idex(bStallIdex),
        .bubble_idex(bBubIdex), .bubble_exmem(bBubExmem),
        .flush_ifid(bFlushIfid), .flush_idex(bFlushIdex),
        .bus_a_fw(bBusA), .bus_b_fw(bBusB), .di_src(bDiSrc), .stall_cnt(bCnt)
    );

    // Advance the given number of clock edges and settle just past the edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Return every control input to the idle value.
    task automatic clearInputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rs2 = '0; mem_rd = '0; wb_rd = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_md_start = 1'b0;
        ex_branch_taken = 1'b0; mem_reg_write = 1'b0; mem_mem_write = 1'b0;
        wb_reg_write = 1'b0; md_done = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with a live forwarding match: outputs must stay quiet.
        clearInputs();
        rst = 1'b1;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        mem_rd = 5'd5; wb_rd = 5'd5; ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        #1;
        checkOutput("rst_busA", 32'(aBusA), 32'd0);
        checkOutput("rst_cnt", aCnt, 32'd0);
        applyStimulus(1);
        rst = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        checkOutput("postrst_busA", 32'(aBusA), 32'd0);
        checkOutput("postrst_flush", 32'(aFlushIfid), 32'd0);
        applyStimulus(1);
        ex_branch_taken = 1'b0;
        ex_rs2 = 5'd0;

        // Forwarding priority on operand A, then operand B.
        #1; checkOutput("fwA_mem", 32'(aBusA), 32'd2);
        mem_rd = 5'd0;
        #1; checkOutput("fwA_wb", 32'(aBusA), 32'd1);
        wb_rd = 5'd0;
        #1; checkOutput("fwA_none", 32'(aBusA), 32'd0);
        mem_rd = 5'd6; wb_rd = 5'd6; ex_rs1 = 5'd0; ex_rs2 = 5'd6;
        #1; checkOutput("fwB_mem", 32'(aBusB), 32'd2);
        checkOutput("fwB_A_idle", 32'(aBusA), 32'd0);
        mem_rd = 5'd0;
        #1; checkOutput("fwB_wb", 32'(aBusB), 32'd1);
        wb_rd = 5'd0;
        #1; checkOutput("fwB_none", 32'(aBusB), 32'd0);
        clearInputs();
        wb_reg_write = 1'b1; wb_rd = 5'd7; mem_rs2 = 5'd7; mem_mem_write = 1'b1;
        #1; checkOutput("diSrc", 32'(aDiSrc), 32'd1);
        mem_mem_write = 1'b0;
        #1; checkOutput("diSrc_nostore", 32'(aDiSrc), 32'd0);
        clearInputs();

        // Load-use: exactly three stall cycles on dutA.
        applyStimulus(1);
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs2 = 5'd4;
        #1;
        checkOutput("ld_c0_stall", 32'(aStallPc), 32'd1);
        checkOutput("ld_c0_bub", 32'(aBubIdex), 32'd1);
        checkOutput("ld_c0_idex", 32'(aStallIdex), 32'd0);
        applyStimulus(1);
        clearInputs();
        #1; checkOutput("ld_c1_stall", 32'(aStallPc), 32'd1);
        applyStimulus(1);
        checkOutput("ld_c2_bub", 32'(aBubIdex), 32'd1);
        applyStimulus(1);
        checkOutput("ld_c3_stall", 32'(aStallPc), 32'd0);
        checkOutput("ld_cnt", aCnt, 32'd3);

        // Load into x0 never stalls.
        ex_mem_read = 1'b1;
        #1; checkOutput("ld_x0", 32'(aStallPc), 32'd0);
        clearInputs();

        // A taken branch during LD_STALL is ignored.
        applyStimulus(1);
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
        applyStimulus(1);
        clearInputs();
        ex_branch_taken = 1'b1;
        #1;
        checkOutput("ldbr_flush", 32'(aFlushIfid), 32'd0);
        checkOutput("ldbr_stall", 32'(aStallPc), 32'd1);
        applyStimulus(1);
        ex_branch_taken = 1'b0;
        applyStimulus(1);
        checkOutput("ldbr_end", 32'(aStallPc), 32'd0);
        checkOutput("ldbr_cnt", aCnt, 32'd6);

        // Mul/div: start at cycle 0, done at cycle 4.
        ex_md_start = 1'b1;
        #1;
        checkOutput("md_c0_stall", 32'(aStallPc), 32'd1);
        checkOutput("md_c0_bubex", 32'(aBubExmem), 32'd1);
        applyStimulus(1);
        ex_md_start = 1'b0;
        #1; checkOutput("md_c1_idex", 32'(aStallIdex), 32'd1);
        applyStimulus(2);
        checkOutput("md_c3_stall", 32'(aStallPc), 32'd1);
        applyStimulus(1);
        md_done = 1'b1;
        #1;
        checkOutput("md_c4_stall", 32'(aStallPc), 32'd0);
        checkOutput("md_c4_bubex", 32'(aBubExmem), 32'd0);
        checkOutput("md_c4_cnt", aCnt, 32'd10);
        applyStimulus(1);
        md_done = 1'b0; ex_branch_taken = 1'b1;
        #1; checkOutput("md_c5_run", 32'(aFlushIdex), 32'd1);
        applyStimulus(1);
        clearInputs();

        // Start and done together: no stall.
        ex_md_start = 1'b1; md_done = 1'b1;
        #1; checkOutput("md_same", 32'(aStallPc), 32'd0);
        applyStimulus(1);
        clearInputs();

        // Branch beats a concurrent load-use.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
        #1;
        checkOutput("sim_flush_ifid", 32'(aFlushIfid), 32'd1);
        checkOutput("sim_flush_idex", 32'(aFlushIdex), 32'd1);
        checkOutput("sim_stall", 32'(aStallPc), 32'd0);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("sim_next_stall", 32'(aStallPc), 32'd0);
        checkOutput("sim_cnt", aCnt, 32'd10);

        // Reset in the second MD_WAIT cycle.
        applyStimulus(1);
        ex_md_start = 1'b1;
        applyStimulus(1);
        ex_md_start = 1'b0;
        #1; checkOutput("mdr_c1_cnt", aCnt, 32'd11);
        applyStimulus(1);
        rst = 1'b1;
        #1;
        checkOutput("mdr_rst_stall", 32'(aStallPc), 32'd0);
        checkOutput("mdr_rst_bubex", 32'(aBubExmem), 32'd0);
        checkOutput("mdr_rst_cnt", aCnt, 32'd0);
        applyStimulus(1);
        rst = 1'b0; ex_branch_taken = 1'b1;
        #1;
        checkOutput("mdr_post_stall", 32'(aStallIdex), 32'd0);
        checkOutput("mdr_post_flush", 32'(aFlushIfid), 32'd0);
        applyStimulus(1);
        ex_branch_taken = 1'b0; md_done = 1'b1;
        #1; checkOutput("mdr_done_stall", 32'(aStallPc), 32'd0);
        applyStimulus(1);
        md_done = 1'b0; ex_branch_taken = 1'b1;
        #1;
        checkOutput("mdr_run_flush", 32'(aFlushIfid), 32'd1);
        checkOutput("mdr_run_cnt", aCnt, 32'd0);
        applyStimulus(1);
        clearInputs();

        // No-forwarding instance: RAW stalls, forwarding selects stay 00.
        ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; ex_rs1 = 5'd3;
        mem_reg_write = 1'b1; mem_rd = 5'd3;
        #1;
        checkOutput("nofw_stall", 32'(bStallPc), 32'd1);
        checkOutput("nofw_bub", 32'(bBubIdex), 32'd1);
        checkOutput("nofw_busA", 32'(bBusA), 32'd0);
        checkOutput("fw_busA_cmp", 32'(aBusA), 32'd2);
        checkOutput("fw_noraw", 32'(aStallPc), 32'd0);
        id_rs1 = 5'd0;
        #1; checkOutput("nofw_release", 32'(bStallPc), 32'd0);
        id_rs1 = 5'd3;
        applyStimulus(2);
        checkOutput("nofw_cnt2", 32'(bCnt), 32'd2);
        applyStimulus(7);
        checkOutput("nofw_sat", 32'(bCnt), 32'd7);
        clearInputs();
        wb_reg_write = 1'b1; wb_rd = 5'd7; mem_rs2 = 5'd7; mem_mem_write = 1'b1;
        #1;
        checkOutput("nofw_disrc", 32'(bDiSrc), 32'd0);
        checkOutput("fw_disrc_cmp", 32'(aDiSrc), 32'd1);
        clearInputs();
        applyStimulus(1);

        $display("[TB] %0d tests run, %0d failed", testCount, errCount);
        $finish;
    end

endmodule
